monobit_freq: RTL and testbench

Parametrised NIST SP 800-22 frequency tester: the next generation of the monobit block. It accepts a qualified serial bit stream, evaluates the monobit (frequency) test over each sequence of `N_BITS` bits, and optionally the block-frequency test over `BLOCK_M`-bit sub-blocks. It produces a registered pass/fail verdict with a one-cycle valid pulse per sequence. It sits between the TRNG bit source and the chip-top output mapping.

---
 rtl/monobit_pkg.sv | 37 +++
 rtl/monobit_blockacc.sv | 96 +++++++++
 rtl/monobit_freq.sv | 139 +++++++++++++
 tb/tb_monobit_freq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/monobit_pkg.sv
// Shared types and sizing helpers for the monobit/block-frequency tester.
// Block-frequency logic is built only when MONOBIT_BLOCK_FREQ_EN is defined.
package monobit_pkg;

    typedef enum logic [1:0] {
        ST_ACC,
        ST_SQ,
        ST_EVAL
    } state_t;

    localparam int DEF_N_BITS     = 128;
    localparam int DEF_MONO_LIMIT = 29;
    localparam int DEF_BLOCK_M    = 16;
    localparam int DEF_CHI_LIMIT  = 80;

    function automatic int s_width(input int n);
        return $clog2(n) + 2;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ones_width(input int m);
        return $clog2(m + 1);
    endfunction

    // Signed d must hold +-BLOCK_M/2 after zero-extending the block count.
    function automatic int d_width(input int m);
        return $clog2(m + 1) + 1;
    endfunction

    function automatic int chi_width(input int n, input int m);
        return $clog2((n / m) * (m / 2) * (m / 2) + 1);
    endfunction

endpackage

// File: rtl/monobit_blockacc.sv
// Block-frequency accumulator: per-block ones count, registered d,
// and the sum of d^2 over one sequence.
module monobit_blockacc
    import monobit_pkg::*;
#(
    parameter int N_BITS  = DEF_N_BITS,
    parameter int BLOCK_M = DEF_BLOCK_M
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic bit_vld,
    input  logic bit_dat,
    input  logic seq_end,
    output logic [chi_width(N_BITS, BLOCK_M)-1:0] chi_final
);

    localparam int PW = cnt_width(BLOCK_M);
    localparam int OW = ones_width(BLOCK_M);
    localparam int DW = d_width(BLOCK_M);
    localparam int CW = chi_width(N_BITS, BLOCK_M);

    logic [PW-1:0]        pos;
    logic [OW-1:0]        blk_ones;
    logic [OW-1:0]        ones_next;
    logic                 blk_end;
    logic signed [DW-1:0] d_next;
    logic signed [DW-1:0] d_q;
    logic [DW-1:0]        d_mag;
    logic [CW-1:0]        d_sq;
    logic                 d_vld;
    logic                 d_last;
    logic [CW-1:0]        chi_acc;
    logic [CW-1:0]        chi_base;

    assign ones_next = blk_ones + OW'(bit_dat);
    assign blk_end   = bit_vld && (pos == PW'(BLOCK_M - 1));
    assign d_next    = $signed(DW'(ones_next)) - $signed(DW'(BLOCK_M / 2));
    assign d_mag     = d_q[DW-1] ? $unsigned(-d_q) : $unsigned(d_q);
    assign d_sq      = CW'(d_mag) * CW'(d_mag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos      <= '0;
            blk_ones <= '0;
        end else if (clear) begin
            pos      <= '0;
            blk_ones <= '0;
        end else if (bit_vld) begin
            if (blk_end) begin
                pos      <= '0;
                blk_ones <= '0;
            end else begin
                pos      <= pos + PW'(1);
                blk_ones <= ones_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q    <= '0;
            d_vld  <= 1'b0;
            d_last <= 1'b0;
        end else begin
            d_vld <= blk_end;
            if (blk_end) begin
                d_q    <= d_next;
                d_last <= seq_end;
            end
        end
    end

    // The last block's d^2 lands one edge after the sequence end, so the
    // partial sum is parked in chi_base while chi_acc restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chi_acc   <= '0;
            chi_base  <= '0;
            chi_final <= '0;
        end else if (clear) begin
            chi_acc <= '0;
        end else begin
            if (seq_end) begin
                chi_base <= chi_acc;
                chi_acc  <= '0;
            end else if (d_vld && !d_last) begin
                chi_acc <= chi_acc + d_sq;
            end
            if (d_vld && d_last) begin
                chi_final <= chi_base + d_sq;
            end
        end
    end

endmodule

// File: rtl/monobit_freq.sv
// NIST SP 800-22 frequency tester: monobit plus optional block-frequency
// (MONOBIT_BLOCK_FREQ_EN) with a registered verdict and valid pulse.
module monobit_freq
    import monobit_pkg::*;
#(
    parameter int N_BITS     = DEF_N_BITS,
    parameter int MONO_LIMIT = DEF_MONO_LIMIT,
    parameter int BLOCK_M    = DEF_BLOCK_M,
    parameter int CHI_LIMIT  = DEF_CHI_LIMIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       epsilon_rsc_dat,
    input  logic       epsilon_vld,
    input  logic       clear,
    output logic       is_random_rsc_dat,
    output logic       valid_rsc_dat,
    output logic       mono_pass,
    output logic       block_pass,
    output logic [7:0] seq_count
);

    localparam int SW = s_width(N_BITS);
    localparam int BW = cnt_width(N_BITS);

    state_t               state;
    state_t               state_nx;
    logic                 sample;
    logic                 seq_end;
    logic                 load;
    logic                 mono_ok;
    logic                 blk_ok;
    logic [BW-1:0]        bit_cnt;
    logic signed [SW-1:0] s_acc;
    logic signed [SW-1:0] s_next;
    logic signed [SW-1:0] s_hold;

    assign sample  = epsilon_vld && !clear;
    assign seq_end = sample && (bit_cnt == BW'(N_BITS - 1));
    assign s_next  = epsilon_rsc_dat ? s_acc + SW'(1) : s_acc - SW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_acc   <= '0;
            bit_cnt <= '0;
            s_hold  <= '0;
        end else if (clear) begin
            s_acc   <= '0;
            bit_cnt <= '0;
        end else if (sample) begin
            if (seq_end) begin
                s_acc   <= '0;
                bit_cnt <= '0;
                s_hold  <= s_next;
            end else begin
                s_acc   <= s_next;
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

`ifdef MONOBIT_BLOCK_FREQ_EN
    logic [chi_width(N_BITS, BLOCK_M)-1:0] chi_final;

    monobit_blockacc #(
        .N_BITS (N_BITS),
        .BLOCK_M(BLOCK_M)
    ) u_blockacc (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .bit_vld  (sample),
        .bit_dat  (epsilon_rsc_dat),
        .seq_end  (seq_end),
        .chi_final(chi_final)
    );

    assign blk_ok = (int'(chi_final) <= CHI_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block_pass <= 1'b0;
        end else if (load) begin
            block_pass <= blk_ok;
        end
    end
`else
    assign blk_ok     = 1'b1;
    assign block_pass = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_nx;
        end
    end

    // Sequence end cannot land in SQ for N_BITS >= 2, but may in EVAL.
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = ST_ACC;
        end else begin
            unique case (state)
                ST_ACC:  state_nx = seq_end ? ST_SQ : ST_ACC;
                ST_SQ:   state_nx = ST_EVAL;
                ST_EVAL: state_nx = seq_end ? ST_SQ : ST_ACC;
                default: state_nx = ST_ACC;
            endcase
        end
    end

    always_comb begin
        load    = (state == ST_EVAL) && !clear;
        mono_ok = (int'(s_hold) <= MONO_LIMIT) &&
                  (int'(s_hold) >= -MONO_LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_random_rsc_dat <= 1'b0;
            valid_rsc_dat     <= 1'b0;
            mono_pass         <= 1'b0;
            seq_count         <= 8'd0;
        end else begin
            valid_rsc_dat <= load;
            if (load) begin
                mono_pass         <= mono_ok;
                is_random_rsc_dat <= mono_ok && blk_ok;
                if (seq_count != 8'hFF) begin
                    seq_count <= seq_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_monobit_freq.sv
// Directed bench for monobit_freq with a sequence-level reference model
// and a per-cycle output comparator.
module tb_monobit_freq;

    localparam int N  = 128;
    localparam int M  = 16;
    localparam int ML = 29;
    localparam int CL = 80;
`ifdef MONOBIT_BLOCK_FREQ_EN
    localparam bit BLK_EN = 1'b1;
`else
    localparam bit BLK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       epsilon_rsc_dat = 1'b0;
    logic       epsilon_vld = 1'b0;
    logic       clear = 1'b0;
    logic       is_random_rsc_dat;
    logic       valid_rsc_dat;
    logic       mono_pass;
    logic       block_pass;
    logic [7:0] seq_count;

    monobit_freq #(
        .N_BITS    (N),
        .MONO_LIMIT(ML),
        .BLOCK_M   (M),
        .CHI_LIMIT (CL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .epsilon_rsc_dat  (epsilon_rsc_dat),
        .epsilon_vld      (epsilon_vld),
        .clear            (clear),
        .is_random_rsc_dat(is_random_rsc_dat),
        .valid_rsc_dat    (valid_rsc_dat),
        .mono_pass        (mono_pass),
        .block_pass       (block_pass),
        .seq_count        (seq_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit seq_bits[$];
    int pend_due[$];
    bit pend_m[$];
    bit pend_b[$];
    int last_s = 0;
    int last_chi = 0;
    bit exp_mono = 0;
    bit exp_blk = 0;
    bit exp_rnd = 0;
    int exp_cnt = 0;
    bit started = 0;
    int pulses = 0;
    int last_pulse = 0;
    int prev_pulse = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset_outputs();
        exp_mono = 0;
        exp_blk  = !BLK_EN;
        exp_rnd  = 0;
        exp_cnt  = 0;
    endfunction

    function automatic void finish_seq(input int e);
        int ones = 0;
        int chi = 0;
        bit m;
        bit b;
        for (int blk = 0; blk < N / M; blk++) begin
            int bo = 0;
            for (int i = 0; i < M; i++) bo += int'(seq_bits[blk * M + i]);
            ones += bo;
            chi += (bo - M / 2) * (bo - M / 2);
        end
        last_s   = ones - (N - ones);
        last_chi = chi;
        m = (last_s <= ML) && (last_s >= -ML);
        b = BLK_EN ? (chi <= CL) : 1'b1;
        pend_due.push_back(e + 2);
        pend_m.push_back(m);
        pend_b.push_back(b);
        seq_bits.delete();
    endfunction

    function automatic void cancel_from(input int e);
        while (pend_due.size() > 0 && pend_due[pend_due.size() - 1] >= e) begin
            void'(pend_due.pop_back());
            void'(pend_m.pop_back());
            void'(pend_b.pop_back());
        end
    endfunction

    task automatic step(input bit b, input bit v, input bit c);
        epsilon_rsc_dat = b;
        epsilon_vld = v;
        clear = c;
        @(posedge clk);
        #1;
        if (c) begin
            seq_bits.delete();
            cancel_from(cyc);
        end else if (v) begin
            seq_bits.push_back(b);
            if (seq_bits.size() == N) finish_seq(cyc);
        end
        epsilon_vld = 1'b0;
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        seq_bits.delete();
        pend_due.delete();
        pend_m.delete();
        pend_b.delete();
        model_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic alt_seq(input bit gaps);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) step(1'b1, 1'b0, 1'b0);
            end
            step(i[0], 1'b1, 1'b0);
        end
    endtask

    // Each block gets cnt[k] ones followed by zeros.
    task automatic block_seq(input int c0, input int c1, input int c2,
                             input int c3, input int c4, input int c5,
                             input int c6, input int c7);
        int cnt[8];
        cnt = '{c0, c1, c2, c3, c4, c5, c6, c7};
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < M; i++) step(i < cnt[k], 1'b1, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (started && !rst) begin
            bit ev;
            while (pend_due.size() > 0 && pend_due[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_valid: got 0 expected 1 (due %0d)",
                         pend_due[0]);
                void'(pend_due.pop_front());
                void'(pend_m.pop_front());
                void'(pend_b.pop_front());
            end
            ev = (pend_due.size() > 0) && (pend_due[0] == cyc);
            chk("valid", int'(valid_rsc_dat), int'(ev));
            if (ev) begin
                exp_mono = pend_m.pop_front();
                exp_blk  = pend_b.pop_front();
                void'(pend_due.pop_front());
                exp_rnd  = exp_mono && exp_blk;
                exp_cnt  = (exp_cnt == 255) ? 255 : exp_cnt + 1;
                pulses++;
                prev_pulse = last_pulse;
                last_pulse = cyc;
            end
            chk("mono_pass", int'(mono_pass), int'(exp_mono));
            chk("block_pass", int'(block_pass), int'(exp_blk));
            chk("is_random", int'(is_random_rsc_dat), int'(exp_rnd));
            chk("seq_count", int'(seq_count), exp_cnt);
        end
    end

    int p0;

    initial begin
        model_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;

        chk("rst_valid", int'(valid_rsc_dat), 0);
        chk("rst_rnd", int'(is_random_rsc_dat), 0);
        chk("rst_mono", int'(mono_pass), 0);
        chk("rst_blk", int'(block_pass), BLK_EN ? 0 : 1);
        chk("rst_cnt", int'(seq_count), 0);

        // All ones
        for (int i = 0; i < N; i++) step(1'b1, 1'b1, 1'b0);
        idle(4);
        chk("ones_S", last_s, 128);
        chk("ones_chi", last_chi, 512);
        chk("ones_mono", int'(mono_pass), 0);
        chk("ones_blk", int'(block_pass), BLK_EN ? 0 : 1);
        chk("ones_rnd", int'(is_random_rsc_dat), 0);
        chk("ones_cnt", int'(seq_count), 1);

        // Alternating, two sequences back to back
        alt_seq(1'b0);
        alt_seq(1'b0);
        idle(4);
        chk("alt_S", last_s, 0);
        chk("alt_chi", last_chi, 0);
        chk("alt_spacing", last_pulse - prev_pulse, 128);
        chk("alt_rnd", int'(is_random_rsc_dat), 1);
        chk("alt_cnt", int'(seq_count), 3);

        // Monobit boundary: S=28 then S=30
        block_seq(10, 10, 10, 10, 10, 10, 9, 9);
        idle(4);
        chk("b28_S", last_s, 28);
        chk("b28_chi", last_chi, 26);
        chk("b28_mono", int'(mono_pass), 1);
        chk("b28_rnd", int'(is_random_rsc_dat), 1);
        block_seq(10, 10, 10, 10, 10, 10, 10, 9);
        idle(4);
        chk("b30_S", last_s, 30);
        chk("b30_chi", last_chi, 29);
        chk("b30_mono", int'(mono_pass), 0);
        chk("b30_rnd", int'(is_random_rsc_dat), 0);

        // Balanced overall, badly unbalanced per block
        block_seq(16, 0, 16, 0, 16, 0, 16, 0);
        idle(4);
        chk("blk_S", last_s, 0);
        chk("blk_chi", last_chi, 512);
        chk("blk_mono", int'(mono_pass), 1);
        chk("blk_pass", int'(block_pass), BLK_EN ? 0 : 1);
        chk("blk_rnd", int'(is_random_rsc_dat), BLK_EN ? 0 : 1);

        // Clear mid-sequence, contiguous then with gaps
        for (int r = 0; r < 2; r++) begin
            p0 = pulses;
            for (int i = 0; i < 64; i++) begin
                if (r == 1) begin
                    while ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, 1'b0);
                end
                step(1'b1, 1'b1, 1'b0);
            end
            step(1'b1, 1'b1, 1'b1);
            alt_seq(r == 1);
            idle(4);
            chk("clr_pulses", pulses - p0, 1);
            chk("clr_rnd", int'(is_random_rsc_dat), 1);
        end

        // Reset at bit 100
        for (int i = 0; i < 99; i++) step(1'b1, 1'b1, 1'b0);
        do_reset();
        chk("rst100_cnt", int'(seq_count), 0);
        chk("rst100_rnd", int'(is_random_rsc_dat), 0);
        alt_seq(1'b0);
        idle(4);
        chk("rst100_next_rnd", int'(is_random_rsc_dat), 1);
        chk("rst100_next_cnt", int'(seq_count), 1);

        // Reset during EVAL
        p0 = pulses;
        alt_seq(1'b0);
        idle(1);
        do_reset();
        idle(4);
        chk("rstev_pulses", pulses - p0, 0);
        chk("rstev_cnt", int'(seq_count), 0);
        chk("rstev_mono", int'(mono_pass), 0);
        alt_seq(1'b0);
        idle(4);
        chk("rstev_next_rnd", int'(is_random_rsc_dat), 1);
        chk("rstev_next_cnt", int'(seq_count), 1);

        idle(4);
        chk("drain", pend_due.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
